// File: rtl/washmachine_pkg.sv
// Shared washing-machine controller definitions: key channel state encoding
// and the key index assignment on the key_raw bus.
package washmachine_pkg;

  typedef enum logic [1:0] {
    KC_IDLE,
    KC_PRESS_WAIT,
    KC_HELD,
    KC_RELEASE_WAIT
  } kc_state_t;

  localparam int KEY_START     = 0;
  localparam int KEY_WATERFULL = 1;
  localparam int KEY_STOP      = 2;

endpackage

// File: rtl/key_debounce_channel.sv
// Single key channel: 2-flop synchroniser, debounce FSM, press/release pulses.
// Optional long-press detector enabled by the KEY_LONGPRESS_EN macro.
// DEBOUNCE_CNT must be at least 2.
module key_debounce_channel
  import washmachine_pkg::*;
#(
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DEBOUNCE_CNT = 20,
  parameter int LONG_CNT     = 2000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  // Pin value of a released key; the synchroniser resets to it.
  localparam logic IDLE_PIN = ACTIVE_LOW;
  localparam int   CW       = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  // The sample that moves the FSM out of a stable state is itself the first
  // stable cycle, so the wait states accept one count earlier. This gives the
  // raw-edge-to-pulse latency of 2 + DEBOUNCE_CNT cycles.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 2);

  logic [1:0]    sync;
  logic          sample;
  kc_state_t     state;
  logic [CW-1:0] cnt;
  logic          accept;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= {2{IDLE_PIN}};
    else       sync <= {sync[0], key_raw};
  end

  // Normalise to pressed = 1.
  assign sample = sync[1] ^ IDLE_PIN;
  assign accept = (state == KC_PRESS_WAIT) && sample && (cnt == CNT_LAST);

  // Debounce FSM with registered level and one-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= KC_IDLE;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        KC_IDLE: begin
          if (sample) begin
            state <= KC_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        KC_PRESS_WAIT: begin
          if (!sample) begin
            state <= KC_IDLE;
          end else if (cnt == CNT_LAST) begin
            state     <= KC_HELD;
            key_press <= 1'b1;
            key_level <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        KC_HELD: begin
          if (!sample) begin
            state <= KC_RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        KC_RELEASE_WAIT: begin
          if (sample) begin
            state <= KC_HELD;
          end else if (cnt == CNT_LAST) begin
            state       <= KC_IDLE;
            key_release <= 1'b1;
            key_level   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= KC_IDLE;
      endcase
    end
  end

`ifdef KEY_LONGPRESS_EN
  localparam int HW = $clog2(LONG_CNT + 1);
  logic [HW-1:0] hcnt;

  // Hold counter: cleared on acceptance, runs through HELD and RELEASE_WAIT,
  // saturates at LONG_CNT so only one long pulse is given per press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt     <= '0;
      key_long <= 1'b0;
    end else begin
      key_long <= 1'b0;
      if (accept) begin
        hcnt <= '0;
      end else if (state == KC_HELD || state == KC_RELEASE_WAIT) begin
        if (hcnt < HW'(LONG_CNT)) begin
          hcnt     <= hcnt + 1'b1;
          key_long <= (hcnt == HW'(LONG_CNT - 1));
        end
      end else begin
        hcnt <= '0;
      end
    end
  end
`else
  logic unused_long;
  assign unused_long = accept ^ (LONG_CNT > 0);
  assign key_long    = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner: N_KEYS independent debounce channels.
// Long-press pulses are generated only when KEY_LONGPRESS_EN is defined.
module key_conditioner
  import washmachine_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DEBOUNCE_CNT = 20,
  parameter int LONG_CNT     = 2000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  // One fully independent channel per key.
  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_channel #(
      .ACTIVE_LOW  (ACTIVE_LOW),
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .LONG_CNT    (LONG_CNT)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .key_raw    (key_raw[g]),
      .key_level  (key_level[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g]),
      .key_long   (key_long[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner (DEBOUNCE_CNT=4, LONG_CNT=10, active-low
// pins). Inputs change just after a rising edge; the first following edge is
// cycle 1, so an accepted change shows its pulse after cycle 6.
module tb_key_conditioner;

  localparam int NK = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] key_level, key_press, key_release, key_long;
  int            n_vec = 0;
  int            n_err = 0;

  key_conditioner #(
    .N_KEYS      (NK),
    .ACTIVE_LOW  (1'b1),
    .DEBOUNCE_CNT(4),
    .LONG_CNT    (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int np, nr, pat, seen;
    reset   = 1'b1;
    key_raw = 4'hF;
    #2;
    chk("rst_level",   32'(key_level),   32'h0);
    chk("rst_press",   32'(key_press),   32'h0);
    chk("rst_release", 32'(key_release), 32'h0);
    chk("rst_long",    32'(key_long),    32'h0);
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();

    // 1. clean press on key 0
    key_raw[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t1_press", 32'(key_press[0]), 32'(i == 6));
      chk("t1_level", 32'(key_level[0]), 32'(i >= 6));
    end

    // 2. bouncing key 1: six 2-cycle segments, then settles pressed
    np = 0; nr = 0; pat = 0;
    for (int seg = 0; seg < 6; seg++) begin
      key_raw[1] = (seg % 2 == 1);
      for (int k = 0; k < 2; k++) begin
        tick();
        np += int'(key_press[1]);
        nr += int'(key_release[1]);
      end
    end
    key_raw[1] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (key_press[1]) begin
        np++;
        pat = i;
      end
      nr += int'(key_release[1]);
    end
    chk("t2_press_cnt", 32'(np),  32'd1);
    chk("t2_press_at",  32'(pat), 32'd6);
    chk("t2_release",   32'(nr),  32'd0);

    // 3. three-cycle glitch on key 2
    key_raw[2] = 1'b0;
    tick(); tick(); tick();
    key_raw[2] = 1'b1;
    seen = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      seen += int'(key_press[2] | key_release[2] | key_level[2]);
    end
    chk("t3_glitch", 32'(seen), 32'd0);

    // 4. simultaneous release of keys 0 and 1
    key_raw[1:0] = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t4_release", 32'(key_release[1:0]), (i == 6) ? 32'd3 : 32'd0);
      chk("t4_level",   32'(key_level[1:0]),   (i >= 6) ? 32'd0 : 32'd3);
    end

    // 5. reset in the middle of a press debounce, keys 2 and 3 held through it
    key_raw[2] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("t5_pre_level", 32'(key_level), 32'h4);
    key_raw[3] = 1'b0;
    tick(); tick(); tick(); tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_level", 32'(key_level), 32'h0);
    chk("t5_async_press", 32'(key_press), 32'h0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t5_press", 32'(key_press), (i == 6) ? 32'hC : 32'h0);
    end
    key_raw = 4'hF;
    for (int i = 0; i < 12; i++) tick();
    chk("t5_idle_level", 32'(key_level), 32'h0);

    // 6. long hold on key 0
    key_raw[0] = 1'b0;
    for (int i = 1; i <= 26; i++) begin
      tick();
`ifdef KEY_LONGPRESS_EN
      chk("t6_long", 32'(key_long), (i == 16) ? 32'h1 : 32'h0);
`else
      chk("t6_long", 32'(key_long), 32'h0);
`endif
      if (i == 20) key_raw[0] = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
